fft_frame_scheduler: RTL and testbench

- Shares the single signal_fft instance between two audio channels (requesters 0 and 1), one whole frame at a time.
- Uses round-robin arbitration, frame-granular locking, and one init pulse per frame.
- Muxes the granted channel's window stream into the FFT and routes both transform output streams back to that channel only.
- Includes a watchdog that aborts a stalled frame.

---
 rtl/fft_sched_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/fft_frame_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and sizing for the FFT frame scheduler.
// Holds the FSM state encoding and the default frame geometry.
package fft_sched_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned N_CH          = 2;
    localparam int unsigned FRAME_LEN_DEF = 512;
    localparam int unsigned BINS_OUT_DEF  = 128;
    localparam int unsigned WDOG_DEF      = 4096;
    localparam int unsigned CNT_W         = 10;
    localparam int unsigned BIN_W         = 8;
    localparam int unsigned WDOG_W        = 13;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer picks the winner only under contention,
// then flips so the other requester wins the next contended round.
module rr_arb2
    import fft_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_req,
    input  logic            i_en,
    output logic [N_CH-1:0] o_gnt_c
);

    logic r_rr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr <= 1'b0;
        end else if (i_en && (&i_req)) begin
            r_rr <= ~r_rr;
        end
    end

    always_comb begin
        o_gnt_c = '0;
        case (i_req)
            2'b01:   o_gnt_c = 2'b01;
            2'b10:   o_gnt_c = 2'b10;
            2'b11:   o_gnt_c = r_rr ? 2'b10 : 2'b01;
            default: o_gnt_c = '0;
        endcase
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Shares one FFT between two channels a whole frame at a time: arbitration,
// window/transform stream routing to the granted channel, and a stall watchdog.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned BINS_OUT  = BINS_OUT_DEF,
    parameter int unsigned WDOG      = WDOG_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     req,
    output logic [N_CH-1:0]     gnt,
    output logic [N_CH-1:0]     done,
    output logic                err,
    input  logic [2*SAMPLE_W-1:0] in_data,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_rdy,
    output logic                fft_init,
    output logic [SAMPLE_W-1:0] fft_window_data,
    output logic                fft_window_valid,
    input  logic                fft_window_rdy,
    input  logic [SAMPLE_W-1:0] fft_t1_real,
    input  logic [SAMPLE_W-1:0] fft_t1_imag,
    input  logic                fft_t1_valid,
    output logic                fft_t1_rdy,
    input  logic [SAMPLE_W-1:0] fft_t2_real,
    input  logic [SAMPLE_W-1:0] fft_t2_imag,
    input  logic                fft_t2_valid,
    output logic                fft_t2_rdy,
    output logic [SAMPLE_W-1:0] out_t1_real,
    output logic [SAMPLE_W-1:0] out_t1_imag,
    output logic [N_CH-1:0]     out_t1_valid,
    input  logic [N_CH-1:0]     out_t1_rdy,
    output logic [6:0]          out_t1_bin,
    output logic [SAMPLE_W-1:0] out_t2_real,
    output logic [SAMPLE_W-1:0] out_t2_imag,
    output logic [N_CH-1:0]     out_t2_valid,
    input  logic [N_CH-1:0]     out_t2_rdy,
    output logic [6:0]          out_t2_bin
);

    state_t            r_state, w_state_nxt;
    logic [N_CH-1:0]   r_gnt, w_gnt_nxt;
    logic [N_CH-1:0]   r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_init, w_init_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [BIN_W-1:0]  r_bin1, w_bin1_nxt;
    logic [BIN_W-1:0]  r_bin2, w_bin2_nxt;
    logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;

    logic [N_CH-1:0] w_arb_gnt;
    logic            w_arb_en;
    logic            w_g;
    logic            w_busy;
    logic            w_win_hs, w_t1_act, w_t2_act, w_t1_hs, w_t2_hs, w_any_hs;
    logic            w_wdog_fire;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (req),
        .i_en    (w_arb_en),
        .o_gnt_c (w_arb_gnt)
    );

    assign w_g         = r_gnt[1];
    assign w_busy      = (r_state == LOAD) || (r_state == DRAIN);
    assign w_win_hs    = (r_state == LOAD) && in_valid[w_g] && fft_window_rdy;
    assign w_t1_act    = (r_state == DRAIN) && (r_bin1 < BIN_W'(BINS_OUT));
    assign w_t2_act    = (r_state == DRAIN) && (r_bin2 < BIN_W'(BINS_OUT));
    assign w_t1_hs     = w_t1_act && fft_t1_valid && out_t1_rdy[w_g];
    assign w_t2_hs     = w_t2_act && fft_t2_valid && out_t2_rdy[w_g];
    assign w_any_hs    = w_win_hs || w_t1_hs || w_t2_hs;
    assign w_wdog_fire = w_busy && !w_any_hs && (r_wdog == WDOG_W'(WDOG - 1));

    // Stream routing: only the granted channel ever sees ready/valid.
    always_comb begin
        in_rdy           = '0;
        fft_window_data  = '0;
        fft_window_valid = 1'b0;
        fft_t1_rdy       = 1'b0;
        fft_t2_rdy       = 1'b0;
        out_t1_real      = '0;
        out_t1_imag      = '0;
        out_t1_valid     = '0;
        out_t2_real      = '0;
        out_t2_imag      = '0;
        out_t2_valid     = '0;
        if (r_state == LOAD) begin
            fft_window_data  = w_g ? in_data[2*SAMPLE_W-1:SAMPLE_W] : in_data[SAMPLE_W-1:0];
            fft_window_valid = in_valid[w_g];
            in_rdy[w_g]      = fft_window_rdy;
        end
        if (r_state == DRAIN) begin
            out_t1_real       = fft_t1_real;
            out_t1_imag       = fft_t1_imag;
            out_t2_real       = fft_t2_real;
            out_t2_imag       = fft_t2_imag;
            out_t1_valid[w_g] = w_t1_act && fft_t1_valid;
            out_t2_valid[w_g] = w_t2_act && fft_t2_valid;
            fft_t1_rdy        = w_t1_act && out_t1_rdy[w_g];
            fft_t2_rdy        = w_t2_act && out_t2_rdy[w_g];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_init_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_bin1_nxt  = r_bin1;
        w_bin2_nxt  = r_bin2;
        w_wdog_nxt  = r_wdog;
        w_arb_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_arb_en    = 1'b1;
                    w_gnt_nxt   = w_arb_gnt;
                    w_init_nxt  = 1'b1;
                    w_state_nxt = INIT;
                end
            end
            INIT: begin
                w_cnt_nxt   = '0;
                w_bin1_nxt  = '0;
                w_bin2_nxt  = '0;
                w_wdog_nxt  = '0;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_win_hs) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_bin1_nxt = r_bin1 + BIN_W'(w_t1_hs);
                w_bin2_nxt = r_bin2 + BIN_W'(w_t2_hs);
                if ((w_bin1_nxt == BIN_W'(BINS_OUT)) && (w_bin2_nxt == BIN_W'(BINS_OUT))) begin
                    w_done_nxt  = r_gnt;
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Any handshake re-arms the watchdog; expiry aborts and re-inits the FFT.
        if (w_busy) begin
            w_wdog_nxt = w_any_hs ? '0 : r_wdog + WDOG_W'(1);
            if (w_wdog_fire) begin
                w_wdog_nxt  = '0;
                w_gnt_nxt   = '0;
                w_err_nxt   = 1'b1;
                w_init_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_init  <= 1'b0;
            r_cnt   <= '0;
            r_bin1  <= '0;
            r_bin2  <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_init  <= w_init_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bin1  <= w_bin1_nxt;
            r_bin2  <= w_bin2_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign fft_init   = r_init;
    assign out_t1_bin = r_bin1[6:0];
    assign out_t2_bin = r_bin2[6:0];

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: reset, stray traffic, single frames,
// contention, output backpressure and watchdog abort.
module tb_fft_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, gnt, done;
    logic        err;
    logic [31:0] in_data;
    logic [1:0]  in_valid, in_rdy;
    logic        fft_init;
    logic [15:0] fft_window_data;
    logic        fft_window_valid, fft_window_rdy;
    logic [15:0] fft_t1_real, fft_t1_imag, fft_t2_real, fft_t2_imag;
    logic        fft_t1_valid, fft_t1_rdy, fft_t2_valid, fft_t2_rdy;
    logic [15:0] out_t1_real, out_t1_imag, out_t2_real, out_t2_imag;
    logic [1:0]  out_t1_valid, out_t1_rdy, out_t2_valid, out_t2_rdy;
    logic [6:0]  out_t1_bin, out_t2_bin;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_frame_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .gnt              (gnt),
        .done             (done),
        .err              (err),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_rdy           (in_rdy),
        .fft_init         (fft_init),
        .fft_window_data  (fft_window_data),
        .fft_window_valid (fft_window_valid),
        .fft_window_rdy   (fft_window_rdy),
        .fft_t1_real      (fft_t1_real),
        .fft_t1_imag      (fft_t1_imag),
        .fft_t1_valid     (fft_t1_valid),
        .fft_t1_rdy       (fft_t1_rdy),
        .fft_t2_real      (fft_t2_real),
        .fft_t2_imag      (fft_t2_imag),
        .fft_t2_valid     (fft_t2_valid),
        .fft_t2_rdy       (fft_t2_rdy),
        .out_t1_real      (out_t1_real),
        .out_t1_imag      (out_t1_imag),
        .out_t1_valid     (out_t1_valid),
        .out_t1_rdy       (out_t1_rdy),
        .out_t1_bin       (out_t1_bin),
        .out_t2_real      (out_t2_real),
        .out_t2_imag      (out_t2_imag),
        .out_t2_valid     (out_t2_valid),
        .out_t2_rdy       (out_t2_rdy),
        .out_t2_bin       (out_t2_bin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(input int ch);
        int cyc = 0;
        while (gnt == 2'b00 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("grant", 32'(gnt), 32'(1 << ch));
        check("init_with_grant", 32'(fft_init), 1);
    endtask

    // Feeds samples 1..n on channel ch; the other channel offers junk throughout.
    task automatic load_samples(input int ch, input int n);
        int acc = 0, cyc = 0, bad = 0, other = 0, stray = 0, inits = 0;
        while (acc < n && cyc < 2000) begin
            in_valid       = 2'b11;
            in_data        = (ch == 1) ? {16'(acc + 1), 16'hDEAD} : {16'hDEAD, 16'(acc + 1)};
            fft_window_rdy = (cyc % 4) != 3;
            fft_t1_valid   = 1'b1;
            fft_t2_valid   = 1'b1;
            #1;
            if (fft_t1_rdy || fft_t2_rdy) stray++;
            if (in_rdy[1 - ch]) other++;
            if (fft_init) inits++;
            if (fft_window_valid && fft_window_rdy) begin
                if (fft_window_data !== 16'(acc + 1) || in_rdy[ch] !== 1'b1) bad++;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("load_count", 32'(acc), 32'(n));
        check("load_data", 32'(bad), 0);
        check("load_other_rdy", 32'(other), 0);
        check("load_stray_ack", 32'(stray), 0);
        check("load_init_pulses", 32'(inits), 1);
    endtask

    // FFT model: streams bins on both ports; t2 output optionally ready 1-in-3.
    task automatic drain(input int ch, input bit bp, input bit clr_req);
        logic [1:0]  m;
        logic [15:0] d1r, d1i, d2r, d2i;
        int n1 = 0, n2 = 0, cyc = 0, bad = 0, over = 0, other = 0, inits = 0, t1c = 0, t2c = 0;
        bit got = 1'b0;
        m = 2'(1 << ch);
        check("no_extra_sample", {29'd0, in_rdy, fft_window_valid}, 0);
        in_valid = 2'b00;
        while (!got && cyc < 2000) begin
            if (done != 2'b00) begin
                got = 1'b1;
            end else begin
                d1r = 16'(n1 * 3);
                d1i = 16'(16'hF000 | n1);
                d2r = 16'(16'h4000 + n2);
                d2i = 16'(n2 * 5);
                fft_t1_valid = 1'b1;
                fft_t1_real  = d1r;
                fft_t1_imag  = d1i;
                fft_t2_valid = 1'b1;
                fft_t2_real  = d2r;
                fft_t2_imag  = d2i;
                out_t1_rdy   = 2'b11;
                out_t2_rdy   = (!bp || (cyc % 3) == 0) ? 2'b11 : 2'b00;
                #1;
                if ((out_t1_valid & ~m) != 2'b00 || (out_t2_valid & ~m) != 2'b00) other++;
                if (fft_init) inits++;
                if (fft_t1_rdy) begin
                    if (n1 >= 128) over++;
                    else begin
                        if (out_t1_valid !== m || out_t1_bin !== 7'(n1) ||
                            out_t1_real !== d1r || out_t1_imag !== d1i) bad++;
                        n1++;
                        t1c = cyc;
                    end
                end else if (n1 >= 128 && out_t1_valid != 2'b00) over++;
                if (fft_t2_rdy) begin
                    if (n2 >= 128) over++;
                    else begin
                        if (out_t2_valid !== m || out_t2_bin !== 7'(n2) ||
                            out_t2_real !== d2r || out_t2_imag !== d2i) bad++;
                        n2++;
                        t2c = cyc;
                    end
                end else if (n2 >= 128 && out_t2_valid != 2'b00) over++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("done_seen", 32'(got), 1);
        check("done_onehot", 32'(done), 32'(m));
        check("t1_beats", 32'(n1), 128);
        check("t2_beats", 32'(n2), 128);
        check("bin_sequence", 32'(bad), 0);
        check("ack_after_sat", 32'(over), 0);
        check("other_ch_valid", 32'(other), 0);
        check("drain_init_pulses", 32'(inits), 0);
        check("done_latency", 32'(cyc - ((t1c > t2c) ? t1c : t2c)), 1);
        if (bp) check("t1_sat_first", 32'(t1c < t2c), 1);
        if (clr_req) req = 2'b00;
        @(posedge clk); #1;
        check("gnt_gap", 32'(gnt), 0);
        check("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int dn;
        rst            = 1'b0;
        req            = 2'b11;
        in_data        = 32'hA5A5_5A5A;
        in_valid       = 2'b11;
        fft_window_rdy = 1'b1;
        fft_t1_real    = 16'h1234;
        fft_t1_imag    = 16'h5678;
        fft_t1_valid   = 1'b1;
        fft_t2_real    = 16'h9ABC;
        fft_t2_imag    = 16'hDEF0;
        fft_t2_valid   = 1'b1;
        out_t1_rdy     = 2'b11;
        out_t2_rdy     = 2'b11;
        #12;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done_err_init", {29'd0, done, err}, 0);
        check("rst_fft_init", 32'(fft_init), 0);
        check("rst_in_rdy", 32'(in_rdy), 0);
        check("rst_window", {15'd0, fft_window_valid, fft_window_data}, 0);
        check("rst_t_rdy", {30'd0, fft_t1_rdy, fft_t2_rdy}, 0);
        check("rst_out_valid", {28'd0, out_t1_valid, out_t2_valid}, 0);
        check("rst_out_data", {out_t1_real, out_t2_imag}, 0);
        req = 2'b00;
        #10 rst = 1'b1;

        // Stray FFT output while idle must not be acknowledged or counted.
        @(posedge clk); #1;
        check("stray_t1_rdy", 32'(fft_t1_rdy), 0);
        check("stray_out_valid", 32'(out_t1_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("stray_t1_rdy_later", 32'(fft_t1_rdy), 0);
        check("stray_bin", 32'(out_t1_bin), 0);
        check("stray_gnt", 32'(gnt), 0);

        // Reset in the middle of a ch0 load, then a full ch1 frame.
        req = 2'b01;
        wait_grant(0);
        load_samples(0, 100);
        rst = 1'b0;
        #1;
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_in_rdy", 32'(in_rdy), 0);
        check("midrst_init", 32'(fft_init), 0);
        #3 rst = 1'b1;
        req = 2'b10;
        wait_grant(1);
        load_samples(1, 512);
        drain(1, 1'b0, 1'b1);

        // Single ch0 frame.
        req = 2'b01;
        wait_grant(0);
        load_samples(0, 512);
        drain(0, 1'b0, 1'b1);

        // Contention: both requesting for three frames alternate 0,1,0.
        req = 2'b11;
        wait_grant(0);
        load_samples(0, 512);
        drain(0, 1'b0, 1'b0);
        wait_grant(1);
        load_samples(1, 512);
        drain(1, 1'b0, 1'b0);
        wait_grant(0);
        load_samples(0, 512);
        drain(0, 1'b0, 1'b1);

        // Backpressure on t2 of ch1.
        req = 2'b10;
        wait_grant(1);
        load_samples(1, 512);
        drain(1, 1'b1, 1'b1);

        // Watchdog: ch0 stalls after 300 samples while ch1 waits.
        req = 2'b01;
        wait_grant(0);
        load_samples(0, 300);
        in_valid = 2'b00;
        req      = 2'b10;
        n  = 0;
        dn = 0;
        while (err == 1'b0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (done != 2'b00) dn++;
        end
        check("wdog_idle_cycles", 32'(n), 4096);
        check("wdog_init", 32'(fft_init), 1);
        check("wdog_gnt", 32'(gnt), 0);
        check("wdog_no_done", 32'(dn), 0);
        @(posedge clk); #1;
        check("wdog_err_one_cycle", 32'(err), 0);
        check("wdog_next_grant", 32'(gnt), 32'h2);
        check("wdog_next_init", 32'(fft_init), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
